// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle for the shared multiply/divide unit.
// The control unit drives the master side; muldiv_unit sits on the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: multiply exits once the multiplier runs out.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;

  logic               in_sgn;
  logic               in_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_top;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0]   rem_mask;
  logic               mrem_zero;
`endif

  always_comb begin
    in_sgn = ~bus.op[0];
    in_div = bus.op[1];
    a_neg  = in_sgn & bus.a[WIDTH-1];
    b_neg  = in_sgn & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
  end

  // Multiplier bits sit in the low half and shift out as the sum shifts in.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_top - {1'b0, m_q};
    if (div_diff[WIDTH])
      div_step = {acc_q[2*WIDTH-2:0], 1'b0};
    else
      div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Low cnt_q bits of the accumulator are still unprocessed multiplier.
  always_comb begin
    rem_mask  = ~({WIDTH{1'b1}} << cnt_q);
    mrem_zero = (acc_q[WIDTH-1:0] & rem_mask) == '0;
    prod      = acc_q >> cnt_q;
  end
`else
  always_comb begin
    prod = acc_q;
  end
`endif

  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quo    = acc_q[WIDTH-1:0];
    rem    = acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sa_q   <= a_neg;
            sb_q   <= b_neg;
            busy_q <= 1'b1;
            dz_q   <= 1'b0;
            cnt_q  <= CW'(WIDTH);
            if (in_div && bus.b == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= RUN;
              m_q     <= in_div ? b_mag : a_mag;
              acc_q   <= {{WIDTH{1'b0}}, in_div ? a_mag : b_mag};
            end
          end
        end
        RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
          if (!op_q[1]) begin
            if (mrem_zero) begin
              state_q <= FIX;
            end else begin
              acc_q <= mul_step;
              cnt_q <= cnt_q - 1'b1;
            end
          end else begin
            acc_q <= div_step;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1))
              state_q <= FIX;
          end
`else
          acc_q <= op_q[1] ? div_step : mul_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1))
            state_q <= FIX;
`endif
        end
        FIX: begin
          if (op_q[1]) begin
            lo_q <= (sa_q ^ sb_q) ? -quo : quo;
            hi_q <= sa_q ? -rem : rem;
          end else begin
            {hi_q, lo_q} <= prod_s;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          // Divide-by-zero arrives here without done set yet.
          if (!done_q) begin
            done_q <= 1'b1;
            dz_q   <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a plain-arithmetic model.
// Honours MULDIV_EARLY_OUT_EN for expected multiply latency.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] e_hi = '0;
  logic [W-1:0] e_lo = '0;
  logic         e_dz = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin
        p = longint'(sa * sb);
        e_hi = p[63:32]; e_lo = p[31:0]; e_dz = 1'b0;
      end
      2'b01: begin
        p = ua * ub;
        e_hi = p[63:32]; e_lo = p[31:0]; e_dz = 1'b0;
      end
      2'b10: begin
        if (b == '0) e_dz = 1'b1;
        else begin
          q = sa / sb; r = sa % sb;
          e_lo = q[31:0]; e_hi = r[31:0]; e_dz = 1'b0;
        end
      end
      default: begin
        if (b == '0) e_dz = 1'b1;
        else begin
          p = ua / ub; q = longint'(ua % ub);
          e_lo = p[31:0]; e_hi = q[31:0]; e_dz = 1'b0;
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op,
                                 input logic [W-1:0] b);
    logic [W-1:0] mag;
    int msb;
    if (op[1] && b == '0) return 1;
    mag = (op == 2'b00 && b[W-1]) ? -b : b;
    msb = -1;
    for (int i = 0; i < W; i++) if (mag[i]) msb = i;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) return (msb < 0) ? 2 : msb + 3;
`endif
    return W + 1;
  endfunction

  task automatic run_op(input logic [1:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input bit noise);
    int lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    model(op, a, b);
    lat = exp_lat(op, b);
    check("busy_acc", 64'(bus.busy), 64'd1);
    seen = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (noise) begin
        bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
        bus.start = (n == 3 && lat > 6);
      end
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1'b1;
        check("latency", 64'(n), 64'(lat));
        break;
      end
    end
    bus.start = 1'b0;
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    check("hi", 64'(bus.hi), 64'(e_hi));
    check("lo", 64'(bus.lo), 64'(e_lo));
    check("div_zero", 64'(bus.div_zero), 64'(e_dz));
    @(posedge clk); #1;
    check("done_pulse", 64'(bus.done), 64'd0);
    check("busy_end", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] sp [4];
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    int lat, dn;
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF; sp[3] = 32'h80000000;

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dz", 64'(bus.div_zero), 64'd0);
    reset = 1'b1;

    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
    check("mult_hi_c", 64'(bus.hi), 64'hFFFFFFFF);
    check("mult_lo_c", 64'(bus.lo), 64'hFFFFFFF1);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_hi_c", 64'(bus.hi), 64'hFFFFFFFE);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_c", 64'(bus.lo), 64'hFFFFFFFD);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("divu_lo_c", 64'(bus.lo), 64'h7FFFFFFC);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf_lo_c", 64'(bus.lo), 64'h80000000);
    run_op(2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    run_op(2'b11, 32'h55555555, 32'h0, 1'b0);
    run_op(2'b01, 32'd2, 32'd3, 1'b0);
    check("mul6_c", 64'(bus.lo), 64'd6);
    run_op(2'b01, 32'hDEADBEEF, 32'd1, 1'b1);
    run_op(2'b00, 32'h7FFFFFFF, 32'h0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run_op(rop, ra, rb, 1'b1);
    end

    // start held high: second accept lands exactly WIDTH+3 after the first
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd7; bus.b = 32'd9;
    @(posedge clk); #1;
    lat = exp_lat(2'b01, 32'd9);
    model(2'b01, 32'd7, 32'd9);
    for (int n = 1; n <= lat + 2; n++) begin
      @(posedge clk); #1;
      if (n == lat) check("b2b_done", 64'(bus.done), 64'd1);
      if (n == lat + 1) check("b2b_idle", 64'(bus.busy), 64'd0);
      if (n == lat + 2) check("b2b_acc", 64'(bus.busy), 64'd1);
    end
    bus.start = 1'b0;
    dn = 0;
    for (int n = 0; n < 100 && dn == 0; n++) begin
      @(posedge clk); #1;
      if (bus.done) dn = 1;
    end
    check("b2b_second", 64'(dn), 64'd1);
    check("b2b_lo", 64'(bus.lo), 64'(e_lo));
    @(posedge clk); #1;

    // reset mid-multiply
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h1234; bus.b = 32'h89AB;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_hi", 64'(bus.hi), 64'd0);
    check("arst_lo", 64'(bus.lo), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    e_hi = '0; e_lo = '0; e_dz = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    for (int n = 0; n < 45; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dn++;
    end
    check("arst_no_done", 64'(dn), 64'd0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
